int_multiplier: RTL and testbench
=================================

# int_multiplier

Sequential shift-add multiplier with a post-add stage that computes `product = in1 * in2 + in3` for unsigned N-bit operands. It is the inverse path of the integer divider: it takes a quotient, divisor and remainder and reconstructs the dividend as `q * y + r`. It sits beside the divider as a self-check and general multiply unit, and uses the same go/done style handshake driven by a small control FSM.

## Interface
- `N`, default 4: operand width; product width is 2N.
- `clk` input, 1 bit: clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `go` input, 1 bit: start request, level-sampled in IDLE.
- `in1` input, N bits: multiplicand (quotient when self-checking).
- `in2` input, N bits: multiplier (divisor).
- `in3` input, N bits: addend (remainder).
- `product` output, 2N bits: result, valid while `done` = 1.
- `done` output, 1 bit: result valid.
- `busy` output, 1 bit: operation in progress (LOAD, CALC or ADD).
- `cs` output, 3 bits: current FSM state, for debug.

## Operation
- FSM states: IDLE, LOAD, CALC, ADD, DONE.
- IDLE:
  - `busy` = 0, `done` = 0.
  - `go` = 1 → LOAD.
- LOAD:
  - Register `A` ← `in1`, `B` ← `in2`, `R` ← `in3`.
  - Accumulator `ACC` (N+1 bits) ← 0.
  - Counter `cnt` ← N.
  - → CALC.
- CALC, one iteration per cycle:
  - If `B[0]` = 1, `sum = ACC[N-1:0] + A` (N+1 bits); otherwise `sum = {1'b0, ACC[N-1:0]}`.
  - The concatenation `{sum, B}` shifts right by one: `ACC` ← `sum >> 1`, `B` ← `{sum[0], B[N-1:1]}`.
  - `cnt` decrements.
  - When `cnt` = 1 at the clock edge, → ADD.
- ADD:
  - `{ACC[N-1:0], B}` ← `{ACC[N-1:0], B} + R`, computed in 2N bits.
  - No overflow is possible: the maximum result is (2^N−1)^2 + 2^N−1 < 2^2N.
  - → DONE.
- DONE:
  - `done` = 1, `product` = `{ACC[N-1:0], B}`, held stable.
  - `go` = 0 → IDLE. `go` still high → remain in DONE (no auto-restart).
- `go` and operand changes while busy are ignored; operands are captured only in LOAD.
- `product` is driven as all zeros outside DONE, gated the same way as the divider's output mux.
- Reset at any time, including mid-CALC:
  - State → IDLE.
  - `A`, `B`, `R`, `ACC`, `cnt` → 0.
  - `product` = 0, `done` = 0, `busy` = 0.

## Timing
- Reset values: `product` = 0, `done` = 0, `busy` = 0, `cs` = IDLE.
- Edge 0 (`go` sampled high in IDLE) → LOAD.
- Edge 1 → CALC.
- Edges 2 … N+1 → the N CALC iterations.
- Edge N+2 → ADD completes, state = DONE.
- `done` rises after edge N+2 (N = 4: the 6th edge after `go` is seen).
- `busy` is high from after edge 0 until after edge N+2.
- `product` is valid in the same cycle `done` is high and stays stable until leaving DONE.
- Minimum back-to-back period: N+4 cycles, because the return through IDLE requires `go` to drop for one cycle.
- Operand edge cases need no special handling:
  - `in2` = 0: all CALC iterations add nothing; result = `in3`.
  - `in1` = 0: result = `in3`.

## Structure
- Shared package `int_mul_pkg`:
  - Parameter `N` default.
  - FSM state encoding constants: IDLE=0, LOAD=1, CALC=2, ADD=3, DONE=4.
- Sub-module `mul_dp`, the datapath. It holds:
  - `A`, `B`, `R` and `ACC` registers.
  - The N-bit adder and the right shifter.
  - The 2N-bit post-adder.
  - `cnt`.
  - The output gating mux.
- Its control inputs are `ld`, `shift`, `add_r` and `ld_cnt`.
- `int_multiplier` contains the FSM and instantiates `mul_dp`, mirroring the divider's control/datapath split.

## Test plan
- Reset, then `go` pulse with `in1`=4, `in2`=3, `in3`=0 → `done` after 6 edges, `product` = 12, `busy` low afterwards.
- Divider inverse: `in1`=7, `in2`=2, `in3`=1 → `product` = 15. Max case: `in1`=15, `in2`=15, `in3`=14 → `product` = 239.
- Zero operands:
  - `in1`=0, `in2`=9, `in3`=5 → 5.
  - `in1`=9, `in2`=0, `in3`=0 → 0.
  - Latency is unchanged in both cases.
- Operands changed and `go` toggled during CALC → result still reflects the values captured in LOAD; `cs` sequence unaffected.
- `go` held high through DONE → `done` stays 1 and `product` stays stable. `go` drops → IDLE with `product` = 0. `go` raised again → new operation.
- Assert `rst` at the 3rd CALC cycle → all outputs 0 and `cs` = IDLE immediately (asynchronous). After release, a new `go` gives a correct result.

Source files
------------

// File: rtl/int_mul_pkg.sv
// Shared definitions for the shift-add multiplier.
// Holds the default operand width and the FSM state encoding, which is also
// exported on the debug port cs.
package int_mul_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CALC = 3'd2,
    ADD  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/mul_dp.sv
// Datapath of the shift-add multiplier: computes in1 * in2 + in3.
// Ports:
//   clk, rst                - clock, asynchronous active-high reset
//   ld                      - capture in1/in2/in3 into A/B/R, clear ACC
//   shift                   - one shift-add iteration
//   add_r                   - add R into the 2N-bit product {ACC, B}
//   ld_cnt                  - preset the iteration counter to N
//   out_en                  - pass the product to the output (else zeros)
//   in1, in2, in3           - multiplicand, multiplier, addend
//   product                 - gated 2N-bit result
//   cnt_one                 - counter is on its last iteration
module mul_dp
  import int_mul_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic           shift,
  input  logic           add_r,
  input  logic           ld_cnt,
  input  logic           out_en,
  input  logic [N-1:0]   in1,
  input  logic [N-1:0]   in2,
  input  logic [N-1:0]   in3,
  output logic [2*N-1:0] product,
  output logic           cnt_one
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [N-1:0]   r;
  // The accumulator only ever stores sum >> 1, whose top bit is always zero,
  // so the stored copy keeps N bits; the carry lives in the N+1-bit sum.
  logic [N-1:0]   acc;
  logic [CW-1:0]  cnt;
  logic [N:0]     sum;
  logic [2*N-1:0] post_sum;

  // NOTE: every combinational output gets a value on every path (default
  // first or full if/else); a missing branch would infer a latch.
  always_comb begin
    sum      = b[0] ? ({1'b0, acc} + {1'b0, a}) : {1'b0, acc};
    post_sum = {acc, b} + {{N{1'b0}}, r};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a   <= '0;
      b   <= '0;
      r   <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      if (ld) begin
        a   <= in1;
        b   <= in2;
        r   <= in3;
        acc <= '0;
      end else if (shift) begin
        // {sum, B} shifted right by one bit.
        acc <= sum[N:1];
        b   <= {sum[0], b[N-1:1]};
      end else if (add_r) begin
        // Cannot overflow: (2^N-1)^2 + (2^N-1) < 2^2N.
        acc <= post_sum[2*N-1:N];
        b   <= post_sum[N-1:0];
      end

      if (ld_cnt) begin
        cnt <= CW'(N);
      end else if (shift) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign cnt_one = (cnt == CW'(1));
  assign product = out_en ? {acc, b} : '0;

endmodule

// File: rtl/int_multiplier.sv
// Sequential multiplier computing product = in1 * in2 + in3 (unsigned).
// Used beside the integer divider to rebuild the dividend as q * y + r.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   go              - start request, sampled in IDLE; must drop to return
//   in1, in2, in3   - multiplicand, multiplier, addend (captured in LOAD)
//   product         - 2N-bit result, non-zero only while done is high
//   done            - result valid
//   busy            - operation in progress (LOAD, CALC, ADD)
//   cs              - current FSM state for debug
module int_multiplier
  import int_mul_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [N-1:0]   in1,
  input  logic [N-1:0]   in2,
  input  logic [N-1:0]   in3,
  output logic [2*N-1:0] product,
  output logic           done,
  output logic           busy,
  output logic [2:0]     cs
);

  state_t state;
  state_t next;
  logic   cnt_one;

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (go) next = LOAD;
      LOAD:    next = CALC;
      CALC:    if (cnt_one) next = ADD;
      ADD:     next = DONE;
      DONE:    if (!go) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // done/busy are registered from the next state so they switch together
  // with the state register.
  // NOTE: control and datapath registers are reset; the design has no
  // memories, so nothing is left uninitialised after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= next;
      done  <= (next == DONE);
      busy  <= (next == LOAD) || (next == CALC) || (next == ADD);
    end
  end

  assign cs = state;

  mul_dp #(.N(N)) u_dp (
    .clk     (clk),
    .rst     (rst),
    .ld      (state == LOAD),
    .shift   (state == CALC),
    .add_r   (state == ADD),
    .ld_cnt  (state == LOAD),
    .out_en  (done),
    .in1     (in1),
    .in2     (in2),
    .in3     (in3),
    .product (product),
    .cnt_one (cnt_one)
  );

endmodule

// File: tb/tb_int_multiplier.sv
module tb_int_multiplier;

  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic           go;
  logic [N-1:0]   in1;
  logic [N-1:0]   in2;
  logic [N-1:0]   in3;
  logic [2*N-1:0] product;
  logic           done;
  logic           busy;
  logic [2:0]     cs;

  int n_checks;
  int n_pass;

  int_multiplier #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .go      (go),
    .in1     (in1),
    .in2     (in2),
    .in3     (in3),
    .product (product),
    .done    (done),
    .busy    (busy),
    .cs      (cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  // Expected state code after the k-th edge following the go-sampling edge,
  // taken from the documented timeline: LOAD(1), CALC(2) for N cycles,
  // ADD(3), DONE(4).
  function automatic int exp_state(input int k);
    if (k == 0) return 1;
    if (k <= N) return 2;
    if (k == N + 1) return 3;
    return 4;
  endfunction

  // One complete operation. hold_go keeps go high through DONE; disturb
  // scrambles operands and go while the multiplier is iterating.
  task automatic run_op(input int a, input int b, input int c,
                        input bit hold_go, input bit disturb);
    int exp_p;
    int edges;
    exp_p = a * b + c;
    @(negedge clk);
    in1 = N'(a);
    in2 = N'(b);
    in3 = N'(c);
    go  = 1'b1;
    @(posedge clk); #1;
    check("cs_load", cs, 1);
    check("busy_load", busy, 1);
    go = hold_go;
    edges = 0;
    while (!done && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (edges <= N + 2) check("cs_seq", cs, exp_state(edges));
      if (disturb && edges < N) begin
        in1 = N'($urandom);
        in2 = N'($urandom);
        in3 = N'($urandom);
        go  = 1'($urandom);
      end else begin
        go = hold_go;
      end
    end
    check("latency", edges, N + 2);
    check("product", product, exp_p);
    check("busy_done", busy, 0);
    if (hold_go) begin
      repeat (3) begin
        @(posedge clk); #1;
        check("hold_done", done, 1);
        check("hold_product", product, exp_p);
      end
      go = 1'b0;
    end
    @(posedge clk); #1;
    check("cs_idle", cs, 0);
    check("product_idle", product, 0);
    check("done_idle", done, 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    go  = 1'b0;
    in1 = '0;
    in2 = '0;
    in3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_product", product, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_cs", cs, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    run_op(4, 3, 0, 1'b0, 1'b0);
    run_op(7, 2, 1, 1'b0, 1'b0);
    run_op(15, 15, 14, 1'b0, 1'b0);
    run_op(0, 9, 5, 1'b0, 1'b0);
    run_op(9, 0, 0, 1'b0, 1'b0);
    run_op(11, 13, 6, 1'b0, 1'b1);
    run_op(5, 6, 7, 1'b1, 1'b0);

    // Asynchronous reset during the third CALC cycle.
    @(negedge clk);
    in1 = 4'd10;
    in2 = 4'd10;
    in3 = 4'd3;
    go  = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_cs", cs, 2);
    rst = 1'b1;
    #1;
    check("arst_cs", cs, 0);
    check("arst_product", product, 0);
    check("arst_done", done, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(10, 10, 3, 1'b0, 1'b0);

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 25; i++) begin
      run_op(int'($urandom_range(15)), int'($urandom_range(15)),
             int'($urandom_range(15)), 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
